// File: rtl/fxdiv_pkg.sv
// rtl/fxdiv_pkg.sv - shared types and constants for the fixed-point divider
// Purpose : state encoding, default widths and the divide-by-zero quotient.
// Ports   : none (package).
package fxdiv_pkg;

   localparam int DVD_W_DEF  = 16;
   localparam int DVS_W_DEF  = 8;
   localparam int FRAC_W_DEF = 8;
   localparam int Q_W_DEF    = DVD_W_DEF + FRAC_W_DEF;

   // Quotient reported for a zero divisor at the default width.
   localparam logic [Q_W_DEF-1:0] DIV0_QUOTIENT = {Q_W_DEF{1'b1}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } fxdiv_state_e;

endpackage

// File: rtl/fxdiv_step.sv
// rtl/fxdiv_step.sv - one combinational restoring-division iteration
// Purpose : shift the next numerator bit into the partial remainder and
//           subtract the divisor when it fits.
// Ports   : rem_i  partial remainder in
//           bit_i  next numerator bit (MSB first)
//           d_i    divisor
//           rem_o  partial remainder out
//           q_o    quotient bit produced by this step
module fxdiv_step #(
   parameter int DVS_W = 8
) (
   input  logic [DVS_W-1:0] rem_i,
   input  logic             bit_i,
   input  logic [DVS_W-1:0] d_i,
   output logic [DVS_W-1:0] rem_o,
   output logic             q_o
);

   logic [DVS_W:0] t;
   logic [DVS_W:0] d_ext;

   // t carries one extra bit so that a remainder just below D, doubled,
   // still compares correctly against D.
   assign t     = {rem_i, bit_i};
   assign d_ext = {1'b0, d_i};
   assign q_o   = (t >= d_ext);
   // When D fits, t - D < D, so the result always fits back in DVS_W bits.
   assign rem_o = q_o ? DVS_W'(t - d_ext) : t[DVS_W-1:0];

endmodule

// File: rtl/fxdiv_unit.sv
// rtl/fxdiv_unit.sv - multi-cycle unsigned 16.8 fixed-point divider
// Purpose : quotient = floor(dividend * 2^FRAC_W / divisor), one restoring
//           step per cycle. Optional macro FXDIV_ZERO_BYPASS_EN sends a zero
//           divisor straight from IDLE to DONE.
// Ports   : Clk, Reset (async, active-high)
//           start        launch on a 0->1 edge while idle
//           dividend     numerator, sampled on the accepted edge
//           divisor      denominator, sampled on the accepted edge
//           busy         divide in progress
//           done         one-cycle completion pulse
//           quotient     Q_W-bit result, held until the next completion
//           remainder    final partial remainder
//           div_by_zero  last op had a zero divisor
module fxdiv_unit
   import fxdiv_pkg::*;
#(
   parameter int DVD_W  = DVD_W_DEF,
   parameter int DVS_W  = DVS_W_DEF,
   parameter int FRAC_W = FRAC_W_DEF
) (
   input  logic                     Clk,
   input  logic                     Reset,
   input  logic                     start,
   input  logic [DVD_W-1:0]         dividend,
   input  logic [DVS_W-1:0]         divisor,
   output logic                     busy,
   output logic                     done,
   output logic [DVD_W+FRAC_W-1:0]  quotient,
   output logic [DVS_W-1:0]         remainder,
   output logic                     div_by_zero
);

   localparam int Q_W   = DVD_W + FRAC_W;
   localparam int CNT_W = $clog2(Q_W);

   fxdiv_state_e     state_q, state_d;
   logic             start_q;
   // Numerator shifts out at the top while quotient bits shift in at the
   // bottom; after Q_W steps this register holds the quotient.
   logic [Q_W-1:0]   num_q, num_d;
   logic [DVS_W-1:0] dvs_q, dvs_d;
   logic [DVS_W-1:0] rem_q, rem_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [Q_W-1:0]   quot_q, quot_d;
   logic [DVS_W-1:0] remo_q, remo_d;
   logic             dbz_q, dbz_d;

   logic             accept;
   logic [DVS_W-1:0] step_rem;
   logic             step_q;

   fxdiv_step #(.DVS_W(DVS_W)) u_step (
      .rem_i (rem_q),
      .bit_i (num_q[Q_W-1]),
      .d_i   (dvs_q),
      .rem_o (step_rem),
      .q_o   (step_q)
   );

   assign accept = start & ~start_q & (state_q == IDLE);

   always_comb begin
      state_d = state_q;
      num_d   = num_q;
      dvs_d   = dvs_q;
      rem_d   = rem_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      quot_d  = quot_q;
      remo_d  = remo_q;
      dbz_d   = dbz_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               num_d   = {dividend, {FRAC_W{1'b0}}};
               dvs_d   = divisor;
               rem_d   = '0;
               cnt_d   = CNT_W'(Q_W - 1);
               dbz_d   = 1'b0;
               state_d = BUSY;
               busy_d  = 1'b1;
`ifdef FXDIV_ZERO_BYPASS_EN
               if (divisor == '0) begin
                  state_d = DONE;
                  busy_d  = 1'b0;
               end
`endif
            end
         end
         BUSY: begin
            num_d = {num_q[Q_W-2:0], step_q};
            rem_d = step_rem;
            if (cnt_q == '0) begin
               state_d = DONE;
               busy_d  = 1'b0;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         DONE: begin
            done_d  = 1'b1;
            state_d = IDLE;
            if (dvs_q == '0) begin
               quot_d = '1;
               remo_d = '0;
               dbz_d  = 1'b1;
            end else begin
               quot_d = num_q;
               remo_d = rem_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q <= IDLE;
         start_q <= 1'b0;
         num_q   <= '0;
         dvs_q   <= '0;
         rem_q   <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         quot_q  <= '0;
         remo_q  <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         start_q <= start;
         num_q   <= num_d;
         dvs_q   <= dvs_d;
         rem_q   <= rem_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         quot_q  <= quot_d;
         remo_q  <= remo_d;
         dbz_q   <= dbz_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign quotient    = quot_q;
   assign remainder   = remo_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_fxdiv_unit.sv
// tb/tb_fxdiv_unit.sv - self-checking bench for fxdiv_unit
module tb_fxdiv_unit;
   import fxdiv_pkg::*;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        start;
   logic [15:0] dividend;
   logic [7:0]  divisor;
   logic        busy;
   logic        done;
   logic [23:0] quotient;
   logic [7:0]  remainder;
   logic        div_by_zero;

   int n_cmp = 0;
   int n_bad = 0;
   int done_cnt = 0;

   fxdiv_unit dut (
      .Clk         (Clk),
      .Reset       (Reset),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 Clk = ~Clk;

   always @(negedge Clk) if (done === 1'b1) done_cnt++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Golden model: top 24 bits of (dividend << 48) / divisor.
   function automatic logic [23:0] ref_q(input logic [15:0] a, input logic [7:0] b);
      logic [63:0] w;
      if (b == 8'd0) return DIV0_QUOTIENT;
      w = (64'(a) << 48) / 64'(b);
      return w[63:40];
   endfunction

   function automatic logic [7:0] ref_r(input logic [15:0] a, input logic [7:0] b);
      logic [31:0] w;
      if (b == 8'd0) return 8'd0;
      w = (32'(a) << 8) % 32'(b);
      return w[7:0];
   endfunction

   function automatic int ref_lat(input logic [7:0] b);
`ifdef FXDIV_ZERO_BYPASS_EN
      if (b == 8'd0) return 1;
`endif
      return 25;
   endfunction

   // hold   : number of cycles after the accept edge that start stays high
   // repulse: cycle at which a fresh start edge is offered (0 = none)
   // tail   : idle cycles after done used to prove no relaunch
   task automatic run_op(input logic [15:0] a, input logic [7:0] b,
                         input int hold, input int repulse, input int tail);
      int lat;
      int cnt0;
      bit seen;
      lat  = 0;
      seen = 0;
      cnt0 = done_cnt;
      @(negedge Clk);
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      @(posedge Clk);
      #1;
      dividend = 16'($urandom);
      divisor  = 8'($urandom);
      for (int i = 1; i <= 60 && !seen; i++) begin
         start = (i < hold) || (repulse != 0 && i == repulse);
         @(posedge Clk);
         #1;
         if (i == 1)
            chk("busy_after_accept", 32'(busy), 32'(ref_lat(b) != 1));
         if (done) begin
            seen = 1;
            lat  = i;
         end
      end
      chk("done_seen", 32'(seen), 32'd1);
      chk("latency", 32'(lat), 32'(ref_lat(b)));
      chk("quotient", 32'(quotient), 32'(ref_q(a, b)));
      chk("remainder", 32'(remainder), 32'(ref_r(a, b)));
      chk("div_by_zero", 32'(div_by_zero), 32'(b == 8'd0));
      chk("busy_at_done", 32'(busy), 32'd0);
      @(posedge Clk);
      #1;
      chk("done_one_cycle", 32'(done), 32'd0);
      repeat (tail) @(posedge Clk);
      #1;
      start = (hold > 60);
      chk("done_count", 32'(done_cnt - cnt0), 32'd1);
      chk("quotient_held", 32'(quotient), 32'(ref_q(a, b)));
   endtask

   initial begin
      logic [15:0] ra;
      logic [7:0]  rb;
      int          cnt0;
      Reset    = 1'b1;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      repeat (3) @(posedge Clk);
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_quotient", 32'(quotient), 32'd0);
      chk("rst_remainder", 32'(remainder), 32'd0);
      chk("rst_dbz", 32'(div_by_zero), 32'd0);
      @(negedge Clk);
      Reset = 1'b0;

      run_op(16'd12800, 8'd25, 1, 0, 2);
      run_op(16'd385, 8'd6, 1, 0, 2);
      run_op(16'd65535, 8'd1, 1, 0, 2);
      run_op(16'd1, 8'd255, 1, 0, 2);
      run_op(16'd4660, 8'd0, 1, 0, 2);
      run_op(16'd0, 8'd7, 1, 0, 2);
      // start held 3 cycles, then re-pulsed while busy: one done only
      run_op(16'd50000, 8'd3, 3, 10, 30);
      // start level held across the return to idle: no relaunch
      run_op(16'd777, 8'd13, 80, 0, 30);
      @(negedge Clk);
      start = 1'b0;

      // reset in the middle of a divide
      cnt0 = done_cnt;
      @(negedge Clk);
      dividend = 16'd385;
      divisor  = 8'd6;
      start    = 1'b1;
      @(posedge Clk);
      #1;
      start = 1'b0;
      repeat (9) @(posedge Clk);
      #2;
      Reset = 1'b1;
      #1;
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_done", 32'(done), 32'd0);
      chk("midrst_quotient", 32'(quotient), 32'd0);
      chk("midrst_remainder", 32'(remainder), 32'd0);
      chk("midrst_dbz", 32'(div_by_zero), 32'd0);
      repeat (2) @(posedge Clk);
      @(negedge Clk);
      Reset = 1'b0;
      repeat (30) @(posedge Clk);
      #1;
      chk("midrst_no_done", 32'(done_cnt - cnt0), 32'd0);
      run_op(16'd385, 8'd6, 1, 0, 2);

      for (int k = 0; k < 40; k++) begin
         ra = 16'($urandom);
         case ($urandom_range(0, 7))
            0:       rb = 8'd0;
            1:       rb = 8'd1;
            2:       rb = 8'($urandom_range(2, 9));
            3:       rb = 8'd255;
            default: rb = 8'($urandom);
         endcase
         run_op(ra, rb, $urandom_range(1, 4), 0, $urandom_range(0, 2));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
